// File: rtl/sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_if
// Brief    : Control, sprite-ROM and pixel-stream signals of sprite_fetch.
// Revision : 1.0
// ============================================================================
interface sprite_fetch_if #(
    parameter int AW = 11,
    parameter int PW = 5
);
    logic          start;
    logic          flip;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] rom_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [PW-1:0] pix_data;
    logic [4:0]    pix_x;
    logic [5:0]    pix_y;
    logic          pix_last;
    logic          busy;
    logic          done;

    modport master (
        output start, flip, base_addr, rom_data, pix_ready,
        input  rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
    );

    modport slave (
        input  start, flip, base_addr, rom_data, pix_ready,
        output rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch
// Brief    : Streams one sprite from ROM in raster order, optional h-mirror.
// Revision : 1.0
// ============================================================================
module sprite_fetch #(
    parameter int SPR_W = 24,
    parameter int SPR_H = 45,
    parameter int AW    = 11,
    parameter int PW    = 5
) (
    input  logic          Clk,
    input  logic          Reset_n,
    sprite_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] c_X_LAST = 5'(SPR_W - 1);
    localparam logic [5:0] c_Y_LAST = 6'(SPR_H - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_flip;
    logic [AW-1:0] r_base;
    logic [4:0]    r_fx;
    logic [5:0]    r_fy;

    logic          r_inflight;
    logic [4:0]    r_inf_x;
    logic [5:0]    r_inf_y;
    logic          r_inf_last;

    logic [PW-1:0] r_qd [2];
    logic [4:0]    r_qx [2];
    logic [5:0]    r_qy [2];
    logic          r_ql [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_occ;
    logic          r_done;

    logic          w_start_acc;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_level;
    logic          w_issue;
    logic          w_fetch_last;
    logic [4:0]    w_col;
    logic [AW-1:0] w_row;

    assign w_start_acc  = (r_state == S_IDLE) && bus.start;
    assign w_pop        = (r_occ != 2'd0) && bus.pix_ready;
    assign w_push       = r_inflight;
    // Slots still committed after this edge: a new read may only be issued
    // if its data will find room when it lands one edge later.
    assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_FETCH) && (w_level < 3'd2);
    assign w_fetch_last = (r_fx == c_X_LAST) && (r_fy == c_Y_LAST);

    assign w_col        = r_flip ? (c_X_LAST - r_fx) : r_fx;
    assign w_row        = AW'(r_fy) * AW'(SPR_W);
    assign bus.rom_addr = r_base + w_row + AW'(w_col);

    assign bus.pix_valid = (r_occ != 2'd0);
    assign bus.pix_data  = r_qd[r_rd_ptr];
    assign bus.pix_x     = r_qx[r_rd_ptr];
    assign bus.pix_y     = r_qy[r_rd_ptr];
    assign bus.pix_last  = r_ql[r_rd_ptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_issue && w_fetch_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && bus.pix_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DRAIN) && w_pop && bus.pix_last;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flip     <= 1'b0;
            r_base     <= '0;
            r_fx       <= '0;
            r_fy       <= '0;
            r_inflight <= 1'b0;
            r_inf_x    <= '0;
            r_inf_y    <= '0;
            r_inf_last <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_flip <= bus.flip;
                r_base <= bus.base_addr;
                r_fx   <= '0;
                r_fy   <= '0;
            end else if (w_issue) begin
                if (r_fx == c_X_LAST) begin
                    r_fx <= '0;
                    r_fy <= r_fy + 6'd1;
                end else begin
                    r_fx <= r_fx + 5'd1;
                end
            end
            r_inflight <= w_issue;
            r_inf_x    <= r_fx;
            r_inf_y    <= r_fy;
            r_inf_last <= w_fetch_last;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_qd[0]  <= '0;
            r_qd[1]  <= '0;
            r_qx[0]  <= '0;
            r_qx[1]  <= '0;
            r_qy[0]  <= '0;
            r_qy[1]  <= '0;
            r_ql[0]  <= 1'b0;
            r_ql[1]  <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_qd[r_wr_ptr] <= bus.rom_data;
                r_qx[r_wr_ptr] <= r_inf_x;
                r_qy[r_wr_ptr] <= r_inf_y;
                r_ql[r_wr_ptr] <= r_inf_last;
                r_wr_ptr       <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch
// Brief    : Self-checking bench for sprite_fetch with a pixel-stream model.
// Revision : 1.0
// ============================================================================
module tb_sprite_fetch;
    typedef struct {
        logic [4:0] d;
        logic [4:0] x;
        logic [5:0] y;
        logic       l;
    } pix_t;

    logic Clk;
    logic Reset_n;
    int   cyc = 0;

    sprite_fetch_if #(.AW(11), .PW(5)) bus ();

    sprite_fetch #(.SPR_W(24), .SPR_H(45), .AW(11), .PW(5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ROM contents: word i holds i mod 32, one-cycle registered read
    always @(posedge Clk) bus.rom_data <= bus.rom_addr[4:0];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_xfer = 0;
    int         n_hold = 0;
    int         acc_cyc = 0;
    int         done_cyc = 0;
    bit         done_seen = 0;
    bit         m_active = 0;
    bit         m_done_exp = 0;
    bit         act_now;
    bit         held = 0;
    logic [16:0] snap;
    pix_t       q[$];
    pix_t       e;
    int         mx, my, ma;
    logic [4:0] log_d [1080];
    logic [4:0] log_x [1080];
    logic [5:0] log_y [1080];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Model: expected stream built from raster rules when a start is honoured
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                n_cmp++;
                if (bus.pix_valid !== 1'b0 || bus.pix_data !== 5'd0 || bus.pix_x !== 5'd0 ||
                    bus.pix_y !== 6'd0 || bus.pix_last !== 1'b0 || bus.busy !== 1'b0 ||
                    bus.done !== 1'b0 || bus.rom_addr !== 11'd0) begin
                    n_bad++;
                    $display("FAIL reset_outputs: got valid=%b data=%0d x=%0d y=%0d last=%b busy=%b done=%b addr=%0d, required all 0",
                             bus.pix_valid, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last,
                             bus.busy, bus.done, bus.rom_addr);
                end
                q.delete();
                m_active   = 0;
                m_done_exp = 0;
                held       = 0;
            end else begin
                act_now = m_active;
                n_cmp++;
                if (bus.busy !== m_active || bus.done !== m_done_exp) begin
                    n_bad++;
                    $display("FAIL busy_done @%0d: got busy=%b done=%b required busy=%b done=%b",
                             cyc, bus.busy, bus.done, m_active, m_done_exp);
                end
                if (bus.done === 1'b1 && !done_seen) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
                m_done_exp = 0;
                if (held) begin
                    n_cmp++;
                    n_hold++;
                    if ({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last} !== snap ||
                        bus.pix_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL hold_stable @%0d: got valid=%b %h required valid=1 %h",
                                 cyc, bus.pix_valid,
                                 {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last}, snap);
                    end
                end
                held = 0;
                if (bus.pix_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pixel @%0d: got valid=1 data=%0d required valid=0",
                                 cyc, bus.pix_data);
                    end else if (bus.pix_ready === 1'b1) begin
                        e = q.pop_front();
                        n_cmp++;
                        if (bus.pix_data !== e.d || bus.pix_x !== e.x ||
                            bus.pix_y !== e.y || bus.pix_last !== e.l) begin
                            n_bad++;
                            $display("FAIL pixel %0d: got d=%0d x=%0d y=%0d l=%b required d=%0d x=%0d y=%0d l=%b",
                                     n_xfer, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last,
                                     e.d, e.x, e.y, e.l);
                        end
                        if (n_xfer < 1080) begin
                            log_d[n_xfer] = bus.pix_data;
                            log_x[n_xfer] = bus.pix_x;
                            log_y[n_xfer] = bus.pix_y;
                        end
                        n_xfer++;
                        if (e.l) begin
                            m_active   = 0;
                            m_done_exp = 1;
                        end
                    end else begin
                        held = 1;
                        snap = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last};
                    end
                end
                if (bus.start === 1'b1 && !act_now) begin
                    for (int n = 0; n < 1080; n++) begin
                        mx  = n % 24;
                        my  = n / 24;
                        ma  = (int'(bus.base_addr) + my * 24 + (bus.flip ? 23 - mx : mx)) % 2048;
                        e.d = 5'(ma % 32);
                        e.x = 5'(mx);
                        e.y = 6'(my);
                        e.l = (n == 1079);
                        q.push_back(e);
                    end
                    m_active  = 1;
                    n_xfer    = 0;
                    acc_cyc   = cyc;
                    done_seen = 0;
                end
            end
        end
    end

    // mode: 0 ready high, 1 random ready, 2 stall at pixel 5,
    //       3 stray start at cycle 100, 4 reset at pixel 500
    task automatic run_sprite(input int mode);
        int  cyc_n = 0;
        bit  fin   = 0;
        bit  once  = 0;
        while (!fin) begin
            @(posedge Clk); #1;
            cyc_n++;
            bus.start     = 1'b0;
            bus.pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && n_xfer == 5 && !once) begin
                once          = 1;
                bus.pix_ready = 1'b0;
                repeat (10) begin
                    @(posedge Clk); #1;
                end
                bus.pix_ready = 1'b1;
            end
            if (mode == 3 && cyc_n == 100) begin
                bus.start     = 1'b1;
                bus.flip      = 1'b1;
                bus.base_addr = 11'd77;
            end
            if (mode == 4 && n_xfer == 500 && !once) begin
                once    = 1;
                Reset_n = 1'b0;
                repeat (3) begin
                    @(posedge Clk); #1;
                end
                Reset_n = 1'b1;
                repeat (20) begin
                    @(posedge Clk); #1;
                end
                fin = 1;
            end
            if (bus.done === 1'b1) fin = 1;
            if (cyc_n > 4000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got no done after %0d cycles, required done", cyc_n);
                fin = 1;
            end
        end
    endtask

    task automatic launch(input logic fl, input logic [10:0] ba);
        bus.flip      = fl;
        bus.base_addr = ba;
        bus.start     = 1'b1;
    endtask

    initial begin
        Reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.flip      = 1'b0;
        bus.base_addr = '0;
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // straight sprite, ready high
        launch(1'b0, 11'd0);
        run_sprite(0);
        @(posedge Clk); #1;
        chk("t1_count", n_xfer, 1080);
        chk("t1_d0", int'(log_d[0]), 0);
        chk("t1_d25", int'(log_d[25]), 25);
        chk("t1_x25", int'(log_x[25]), 1);
        chk("t1_y25", int'(log_y[25]), 1);
        chk("t1_d1079", int'(log_d[1079]), 23);
        chk("t1_y1079", int'(log_y[1079]), 44);
        chk("t1_done_latency", done_cyc - acc_cyc, 1083);

        // mirrored sprite
        launch(1'b1, 11'd0);
        run_sprite(0);
        @(posedge Clk); #1;
        chk("t2_d0", int'(log_d[0]), 23);
        chk("t2_x0", int'(log_x[0]), 0);
        chk("t2_d23", int'(log_d[23]), 0);
        chk("t2_d24", int'(log_d[24]), 15);

        // random backpressure
        launch(1'b0, 11'd0);
        run_sprite(1);
        @(posedge Clk); #1;
        chk("t3_count", n_xfer, 1080);
        chk("t3_d1079", int'(log_d[1079]), 23);

        // ten-cycle stall on pixel 5
        launch(1'b0, 11'd0);
        run_sprite(2);
        @(posedge Clk); #1;
        chk("t4_d5", int'(log_d[5]), 5);
        chk("t4_d6", int'(log_d[6]), 6);
        chk("t4_hold_ge9", int'(n_hold >= 9), 1);

        // stray start mid-sprite, then a start coincident with done
        launch(1'b0, 11'd0);
        run_sprite(3);
        chk("t5a_count", n_xfer, 1080);
        launch(1'b0, 11'd100);
        run_sprite(0);
        @(posedge Clk); #1;
        chk("t5b_d0", int'(log_d[0]), 4);
        chk("t5b_done_latency", done_cyc - acc_cyc, 1083);

        // reset at pixel 500, then a fresh full sprite
        launch(1'b0, 11'd0);
        run_sprite(4);
        chk("t6_no_done", int'(done_seen), 0);
        launch(1'b1, 11'd5);
        run_sprite(0);
        @(posedge Clk); #1;
        chk("t6_count", n_xfer, 1080);
        chk("t6_d0", int'(log_d[0]), 28);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter SPR_W, default 24, sprite width in pixels.
REQ-002 Parameter SPR_H, default 45, sprite height in pixels (SPR_W*SPR_H = 1080 = one sprite bank).
REQ-003 Parameter AW, default 11, ROM address width.
REQ-004 Parameter PW, default 5, encoded pixel width.
REQ-005 Clk  in  1  single clock; all state updates on rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to stream one sprite; honoured only in IDLE.
REQ-008 flip  in  1  horizontal mirror select; sampled with start.
REQ-009 base_addr  in  AW  ROM address of sprite pixel (0,0); sampled with start.
REQ-010 rom_addr  out  AW  address to sprite ROM; combinational from latched base and fetch counters.
REQ-011 rom_data  in  PW  ROM read data; valid one cycle after the edge that sampled rom_addr.
REQ-012 pix_valid  out  1  output pixel available.
REQ-013 pix_ready  in  1  downstream accepts pixel; transfer = pix_valid & pix_ready at a rising edge.
REQ-014 pix_data  out  PW  encoded pixel.
REQ-015 pix_x  out  5  column of pix_data in screen orientation (0..SPR_W-1).
REQ-016 pix_y  out  6  row of pix_data (0..SPR_H-1).
REQ-017 pix_last  out  1  high with the final pixel (x=SPR_W-1, y=SPR_H-1).
REQ-018 busy  out  1  high in FETCH and DRAIN.
REQ-019 done  out  1  one-cycle pulse after final pixel transferred.

Function
REQ-020 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN on the edge issuing the last ROM read; DRAIN->IDLE on the edge transferring pix_last.
REQ-021 On IDLE->FETCH: latch flip and base_addr; clear fetch counters fx, fy to 0.
REQ-022 rom_addr = base + fy*SPR_W + (flip ? SPR_W-1-fx : fx), computed modulo 2^AW.
REQ-023 Read issued at an edge in FETCH when occ + inflight - pop < 2 (occ = FIFO count 0..2, inflight = read issued previous edge, pop = transfer this edge).
REQ-024 On issue fx increments; at fx=SPR_W-1 it wraps to 0 and fy increments; issue at fx=SPR_W-1, fy=SPR_H-1 is the last.
REQ-025 rom_data pushed into a 2-entry output FIFO on the edge after issue, tagged with screen x (=fx at issue), y, last flag.
REQ-026 pix_valid = FIFO non-empty; pix_data/x/y/last from FIFO head; push and pop in the same edge leave occ unchanged.
REQ-027 FIFO never overflows; rom_data never dropped under any pix_ready pattern.
REQ-028 With pix_ready held high: start at edge 0, first issue edge 1, pix_valid after edge 2, one pixel per cycle thereafter, last transfer edge SPR_W*SPR_H+2.
REQ-029 pix_ready low holds head and all outputs stable; reads stall per REQ-023.
REQ-030 start while busy ignored; start in the cycle done is high begins a new sprite.
REQ-031 done high exactly one cycle after DRAIN->IDLE; busy low in that same cycle.
REQ-032 Pixels emitted in raster order (y major, x ascending) regardless of flip.

Reset
REQ-033 Reset_n low immediately forces IDLE, counters/FIFO/inflight cleared, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, busy=0, done=0; rom_addr=0.
REQ-034 Reset mid-sprite abandons the sprite; no pixel and no done emitted after release until a new start.

Verification
REQ-035 base=0, flip=0, ready=1, ROM[i]=i mod 32 -> 1080 pixels, pixel n data = n mod 32, x=n mod 24, y=n/24, pix_last only on n=1079, done one cycle after edge 1082.
REQ-036 base=0, flip=1 -> row 0 data = 23,22,...,0 at x=0..23; row 1 starts with 47 mod 32=15.
REQ-037 ready random 50% -> sequence identical to REQ-035, no loss/duplication, occ never >2.
REQ-038 ready low 10 cycles at pixel 5 -> pixel 5 outputs held stable, resumes with pixel 5 then 6.
REQ-039 start pulsed at cycle 100 mid-sprite -> ignored; start coincident with done -> second sprite streams back-to-back.
REQ-040 Reset_n low at pixel 500 for 3 cycles -> all outputs zero, no done; new start yields full 1080-pixel sprite.
